// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and its code FIFO.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    RELEASE = 2'd2
  } kp_state_e;

  // Set in the code MSB to distinguish operation pins from matrix keys
  localparam logic OP_CODE_MSB = 1'b1;

  function automatic int unsigned calc_data_w(input int unsigned rows,
                                              input int unsigned cols,
                                              input int unsigned num_ops);
    int unsigned key_w;
    int unsigned op_w;
    key_w = $clog2(rows * cols);
    op_w  = $clog2(num_ops);
    return 1 + ((key_w > op_w) ? key_w : op_w);
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Synchronous FIFO with registered head/valid and a registered push-dropped pulse.
module keypad_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, drop_q;
  logic             full, empty, do_push, do_pop, drop_d;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    do_pop  = pop_i && !empty;
    do_push = push_i && (!full || do_pop);
    drop_d  = push_i && full && !do_pop;
    wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
    // New head bypasses memory when it is the entry being written now
    if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
      head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      head_q  <= head_d;
      valid_q <= (wr_d != rd_d);
      drop_q  <= drop_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix + op-pin keypad front end: row scan, priority decode, release
// debounce FSM and a buffered valid/ready code output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned NUM_OPS        = 7,
  parameter int unsigned SCAN_DIV       = 2,
  parameter int unsigned DEBOUNCE_SCANS = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  localparam int unsigned DATA_W        = calc_data_w(ROWS, COLS, NUM_OPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ROWS-1:0]     o_word_lines,
  input  logic [COLS-1:0]     i_bit_lines,
  input  logic [NUM_OPS-1:0]  i_op_pins,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_overflow
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned KEY_W = $clog2(ROWS * COLS);
  localparam int unsigned OP_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int unsigned REL_W = $clog2(DEBOUNCE_SCANS + 1);

  kp_state_e         state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DIV_W-1:0]  dwell_q, dwell_d;
  logic [ROWS-1:0]   word_q, word_d;
  logic              frame_hit_q, frame_hit_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic [REL_W-1:0]  rel_q, rel_d, rel_inc;

  logic              sample, frame_end, sample_valid, hit_now, push;
  logic              op_hit, col_hit;
  logic [OP_W-1:0]   op_idx;
  logic [COL_W-1:0]  col_idx;
  logic [KEY_W-1:0]  key_idx;
  logic [DATA_W-1:0] samp_code;

  // Row dwell counter; the sample is taken in the last dwell cycle of each row
  always_comb begin
    sample    = (dwell_q == DIV_W'(SCAN_DIV - 1));
    frame_end = sample && (row_q == ROW_W'(ROWS - 1));
    dwell_d   = sample ? '0 : DIV_W'(dwell_q + DIV_W'(1));
    row_d     = row_q;
    if (sample) begin
      row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : ROW_W'(row_q + ROW_W'(1));
    end
    word_d = ROWS'(1) << row_d;
  end

  // Lowest op pin wins over everything; otherwise highest active column
  always_comb begin
    op_hit  = |i_op_pins;
    col_hit = |i_bit_lines;
    op_idx  = '0;
    for (int i = int'(NUM_OPS) - 1; i >= 0; i--) begin
      if (i_op_pins[i]) op_idx = OP_W'(i);
    end
    col_idx = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      if (i_bit_lines[c]) col_idx = COL_W'(c);
    end
    key_idx      = KEY_W'(32'(row_q) * COLS + 32'(col_idx));
    samp_code    = op_hit ? {OP_CODE_MSB, (DATA_W-1)'(op_idx)}
                          : {1'b0, (DATA_W-1)'(key_idx)};
    sample_valid = sample && (op_hit || col_hit);
    hit_now      = frame_hit_q || sample_valid;
    frame_hit_d  = frame_end ? 1'b0 : hit_now;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    rel_d   = rel_q;
    push    = 1'b0;
    rel_inc = REL_W'(rel_q + REL_W'(1));
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          state_d = HELD;
          code_d  = samp_code;
        end
      end
      HELD: begin
        if (sample_valid) begin
          code_d = samp_code;
        end else if (frame_end && !hit_now) begin
          if (DEBOUNCE_SCANS == 1) begin
            push    = 1'b1;
            state_d = IDLE;
            rel_d   = '0;
          end else begin
            state_d = RELEASE;
            rel_d   = REL_W'(1);
          end
        end
      end
      RELEASE: begin
        // A bounce restarts the release count and takes the newer code
        if (sample_valid) begin
          state_d = HELD;
          rel_d   = '0;
          code_d  = samp_code;
        end else if (frame_end && !hit_now) begin
          if (rel_inc == REL_W'(DEBOUNCE_SCANS)) begin
            push    = 1'b1;
            state_d = IDLE;
            rel_d   = '0;
          end else begin
            rel_d = rel_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      dwell_q     <= '0;
      word_q      <= ROWS'(1);
      frame_hit_q <= 1'b0;
      code_q      <= '0;
      rel_q       <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      word_q      <= word_d;
      frame_hit_q <= frame_hit_d;
      code_q      <= code_d;
      rel_q       <= rel_d;
    end
  end

  keypad_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (code_q),
    .pop_i       (i_ready),
    .head_o      (o_data),
    .valid_o     (o_valid),
    .drop_o      (o_overflow)
  );

  assign o_word_lines = word_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: default 4x4 instance plus a 3x5 instance.
module tb_keypad_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n, rst2_n;
  logic [3:0] w1, bl1;
  logic [6:0] op1;
  logic [4:0] d1;
  logic       v1, rdy1, ov1;
  logic [2:0] w2;
  logic [4:0] bl2;
  logic [6:0] op2;
  logic [4:0] d2;
  logic       v2, rdy2, ov2;

  logic [1:0] key_row;
  logic [4:0] key_bits;
  logic       key_en1, key_en2;

  int checks = 0;
  int errors = 0;

  // Button matrix model: a pressed key connects its row's word line to its columns
  always_comb begin
    bl1 = (key_en1 && w1[key_row]) ? key_bits[3:0] : 4'b0000;
    bl2 = 5'b00000;
    for (int r = 0; r < 3; r++) begin
      if (key_en2 && w2[r] && (int'(key_row) == r)) bl2 = key_bits;
    end
  end

  keypad_scanner dut1 (
    .clk(clk), .rst_n(rst1_n), .o_word_lines(w1), .i_bit_lines(bl1),
    .i_op_pins(op1), .o_data(d1), .o_valid(v1), .i_ready(rdy1), .o_overflow(ov1)
  );

  keypad_scanner #(.ROWS(3), .COLS(5), .SCAN_DIV(3)) dut2 (
    .clk(clk), .rst_n(rst2_n), .o_word_lines(w2), .i_bit_lines(bl2),
    .i_op_pins(op2), .o_data(d2), .o_valid(v2), .i_ready(rdy2), .o_overflow(ov2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns at the negedge just before a frame-end sampling edge
  task automatic wait_fe(input bit sel);
    int run;
    int div;
    bit found;
    run = 0;
    found = 1'b0;
    div = sel ? 3 : 2;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (sel ? w2[2] : w1[3]) run++; else run = 0;
      if (run == div) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL frame_end_timeout: got none expected frame end within 200 cycles");
    end
  endtask

  task automatic set_key(input bit sel, input logic [6:0] op, input logic [1:0] row,
                         input logic [4:0] bits);
    key_row  = row;
    key_bits = bits;
    if (sel) key_en2 = 1'b1;
    else begin
      key_en1 = 1'b1;
      op1     = op;
    end
  endtask

  task automatic release_key();
    key_en1 = 1'b0;
    key_en2 = 1'b0;
    op1     = '0;
  endtask

  // Hold across a full frame, release, then stop before the first clean frame end
  task automatic start_release(input bit sel, input logic [6:0] op, input logic [1:0] row,
                               input logic [4:0] bits);
    set_key(sel, op, row, bits);
    wait_fe(sel);
    wait_fe(sel);
    @(negedge clk);
    release_key();
    wait_fe(sel);
  endtask

  // Ends at the negedge right after the commit edge
  task automatic commit_key(input bit sel, input logic [6:0] op, input logic [1:0] row,
                            input logic [4:0] bits, input bit pop_at_commit);
    start_release(sel, op, row, bits);
    wait_fe(sel);
    if (pop_at_commit) begin
      if (sel) rdy2 = 1'b1; else rdy1 = 1'b1;
    end
    @(negedge clk);
    rdy1 = 1'b0;
    rdy2 = 1'b0;
  endtask

  task automatic pop(input bit sel);
    if (sel) rdy2 = 1'b1; else rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
    rdy2 = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [1:0] row;
    logic [3:0] bits;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[8];

  typedef struct {
    logic [6:0] op;
    logic [1:0] row;
    logic [3:0] bits;
    logic [4:0] exp;
  } seq_t;

  seq_t ovf[5];
  seq_t fpp[5];

  initial begin
    vecs[0] = '{"r2c1",      7'b0000000, 2'd2, 4'b0010, 5'b01001};
    vecs[1] = '{"op1_r0c3",  7'b0000010, 2'd0, 4'b1000, 5'b10001};
    vecs[2] = '{"op1_op4",   7'b0010010, 2'd0, 4'b0000, 5'b10001};
    vecs[3] = '{"r1_0101",   7'b0000000, 2'd1, 4'b0101, 5'b00110};
    vecs[4] = '{"op6",       7'b1000000, 2'd0, 4'b0000, 5'b10110};
    vecs[5] = '{"r3c0",      7'b0000000, 2'd3, 4'b0001, 5'b01100};
    vecs[6] = '{"r0c0",      7'b0000000, 2'd0, 4'b0001, 5'b00000};
    vecs[7] = '{"r3c3",      7'b0000000, 2'd3, 4'b1000, 5'b01111};

    ovf[0] = '{7'b0000000, 2'd0, 4'b0010, 5'b00001};
    ovf[1] = '{7'b0000000, 2'd1, 4'b0001, 5'b00100};
    ovf[2] = '{7'b0000000, 2'd2, 4'b1000, 5'b01011};
    ovf[3] = '{7'b0000000, 2'd3, 4'b0100, 5'b01110};
    ovf[4] = '{7'b0000100, 2'd0, 4'b0000, 5'b10010};

    fpp[0] = '{7'b0000001, 2'd0, 4'b0000, 5'b10000};
    fpp[1] = '{7'b0000000, 2'd3, 4'b1111, 5'b01111};
    fpp[2] = '{7'b0000000, 2'd1, 4'b1010, 5'b00111};
    fpp[3] = '{7'b0000000, 2'd2, 4'b0001, 5'b01000};
    fpp[4] = '{7'b0000000, 2'd0, 4'b1000, 5'b00011};

    rst1_n = 1'b0; rst2_n = 1'b0;
    op1 = '0; op2 = '0; rdy1 = 1'b0; rdy2 = 1'b0;
    key_row = '0; key_bits = '0; key_en1 = 1'b0; key_en2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_word1", 32'(w1), 32'h1);
    check("rst_valid1", 32'(v1), 32'h0);
    check("rst_data1", 32'(d1), 32'h0);
    check("rst_ovf1", 32'(ov1), 32'h0);
    check("rst_word2", 32'(w2), 32'h1);
    check("rst_valid2", 32'(v2), 32'h0);
    rst1_n = 1'b1; rst2_n = 1'b1;

    // Single commits with i_ready low: code must sit stable until popped
    for (int i = 0; i < 8; i++) begin
      commit_key(1'b0, vecs[i].op, vecs[i].row, {1'b0, vecs[i].bits}, 1'b0);
      check({vecs[i].name, "_valid"}, 32'(v1), 32'h1);
      check({vecs[i].name, "_data"}, 32'(d1), 32'(vecs[i].exp));
      check({vecs[i].name, "_ovf"}, 32'(ov1), 32'h0);
      repeat (10) @(negedge clk);
      check({vecs[i].name, "_hold"}, 32'({v1, d1}), 32'({1'b1, vecs[i].exp}));
      pop(1'b0);
      check({vecs[i].name, "_empty"}, 32'(v1), 32'h0);
    end

    // Bounce landing on the would-be commit frame end
    start_release(1'b0, 7'b0, 2'd2, 5'b00010);
    @(negedge clk);
    set_key(1'b0, 7'b0, 2'd3, 5'b00001);
    wait_fe(1'b0);
    check("bounce_no_early", 32'(v1), 32'h0);
    @(negedge clk);
    release_key();
    wait_fe(1'b0);
    wait_fe(1'b0);
    @(negedge clk);
    check("bounce_data", 32'({v1, d1}), 32'({1'b1, 5'b01100}));
    pop(1'b0);
    check("bounce_single", 32'(v1), 32'h0);

    // Overflow: 5 commits into a depth-4 FIFO
    for (int i = 0; i < 5; i++) begin
      commit_key(1'b0, ovf[i].op, ovf[i].row, {1'b0, ovf[i].bits}, 1'b0);
      check($sformatf("ovf_pulse%0d", i), 32'(ov1), (i == 4) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    check("ovf_pulse_end", 32'(ov1), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d", i), 32'({v1, d1}), 32'({1'b1, ovf[i].exp}));
      pop(1'b0);
    end
    check("ovf_drained", 32'(v1), 32'h0);

    // Full FIFO with commit and pop on the same edge
    for (int i = 0; i < 5; i++) begin
      commit_key(1'b0, fpp[i].op, fpp[i].row, {1'b0, fpp[i].bits}, i == 4);
    end
    check("fpp_no_ovf", 32'(ov1), 32'h0);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("fpp_drain%0d", i), 32'({v1, d1}), 32'({1'b1, fpp[i].exp}));
      pop(1'b0);
    end
    check("fpp_drained", 32'(v1), 32'h0);

    // Async reset in RELEASE with one code already buffered
    commit_key(1'b0, 7'b0, 2'd3, 5'b01000, 1'b0);
    check("pre_rst_valid", 32'(v1), 32'h1);
    start_release(1'b0, 7'b0, 2'd1, 5'b00010);
    repeat (3) @(negedge clk);
    #2 rst1_n = 1'b0;
    #1;
    check("arst_word1", 32'(w1), 32'h1);
    check("arst_out1", 32'({v1, d1, ov1}), 32'h0);
    @(negedge clk);
    rst1_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      repeat (80) begin
        @(negedge clk);
        if (v1) seen = 1'b1;
      end
      check("arst_no_commit1", 32'(seen), 32'h0);
    end

    // 3x5, SCAN_DIV=3 instance
    commit_key(1'b1, 7'b0, 2'd1, 5'b01000, 1'b0);
    check("d2_r1c3", 32'({v2, d2}), 32'({1'b1, 5'b01000}));
    start_release(1'b1, 7'b0, 2'd2, 5'b10000);
    repeat (4) @(negedge clk);
    #2 rst2_n = 1'b0;
    #1;
    check("arst_word2", 32'(w2), 32'h1);
    check("arst_out2", 32'({v2, d2, ov2}), 32'h0);
    @(negedge clk);
    rst2_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      repeat (100) begin
        @(negedge clk);
        if (v2) seen = 1'b1;
      end
      check("arst_no_commit2", 32'(seen), 32'h0);
    end
    commit_key(1'b1, 7'b0, 2'd2, 5'b10000, 1'b0);
    check("d2_r2c4", 32'({v2, d2}), 32'({1'b1, 5'b01110}));
    pop(1'b1);
    check("d2_empty", 32'(v2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
